// File: rtl/uram_coeff_bank.sv
// Multi-bank coefficient store: NUM_BANKS independent single-port URAM banks,
// each with its own request channel, a registered read pipeline and a shared clear engine.
module uram_coeff_bank #(
    parameter int DATA_WIDTH     = 72,
    parameter int ADDR_WIDTH     = 12,
    parameter int NUM_BANKS      = 4,
    parameter int READ_LATENCY   = 2,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    output logic                            busy,
    input  logic [NUM_BANKS-1:0]            req_valid,
    input  logic [NUM_BANKS-1:0]            req_we,
    input  logic [NUM_BANKS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] req_data,
    output logic [NUM_BANKS-1:0]            rd_valid,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic [ADDR_WIDTH-1:0] w_clr_addr_next;
    logic                  w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (CLEAR_ON_RESET) r_state <= ST_CLEAR;
            else                r_state <= ST_READY;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_next;
            r_clr_addr <= w_clr_addr_next;
        end
    end

    // A clear seen during the sweep restarts it from address 0.
    always_comb begin
        w_state_next    = r_state;
        w_clr_addr_next = r_clr_addr;
        case (r_state)
            ST_READY: begin
                if (clear) begin
                    w_state_next    = ST_CLEAR;
                    w_clr_addr_next = '0;
                end
            end
            ST_CLEAR: begin
                if (clear) begin
                    w_clr_addr_next = '0;
                end else if (r_clr_addr == {ADDR_WIDTH{1'b1}}) begin
                    w_state_next    = ST_READY;
                    w_clr_addr_next = '0;
                end else begin
                    w_clr_addr_next = r_clr_addr + 1'b1;
                end
            end
            default: begin
                w_state_next    = ST_READY;
                w_clr_addr_next = '0;
            end
        endcase
    end

    assign w_busy = (r_state == ST_CLEAR);
    assign busy   = w_busy;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic [ADDR_WIDTH-1:0]   w_req_addr;
            logic [DATA_WIDTH-1:0]   w_req_data;
            logic                    w_rd_acc;
            logic                    w_wr_acc;
            logic                    w_port_we;
            logic [ADDR_WIDTH-1:0]   w_port_addr;
            logic [DATA_WIDTH-1:0]   w_port_wdata;
            logic [DATA_WIDTH-1:0]   w_last_in;
            logic [DATA_WIDTH-1:0]   r_ram_q;
            logic [DATA_WIDTH-1:0]   r_rd_data;
            logic [READ_LATENCY:0]   r_vld;

            (* ram_style = "ultra" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];

            assign w_req_addr = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_req_data = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_rd_acc   = ~w_busy & req_valid[gi] & ~req_we[gi];
            assign w_wr_acc   = ~w_busy & req_valid[gi] & req_we[gi];

            // One physical port: the clear engine takes it over while busy.
            assign w_port_we    = w_busy | w_wr_acc;
            assign w_port_addr  = w_busy ? r_clr_addr : w_req_addr;
            assign w_port_wdata = w_busy ? '0 : w_req_data;

            // Read-first: the array read sees the word from before this edge's write.
            always_ff @(posedge clk) begin
                if (w_port_we) r_mem[w_port_addr] <= w_port_wdata;
                if (w_rd_acc)  r_ram_q <= r_mem[w_port_addr];
            end

            if (READ_LATENCY > 1) begin : g_casc
                logic [DATA_WIDTH-1:0] r_casc [READ_LATENCY-1];
                always_ff @(posedge clk) begin
                    r_casc[0] <= r_ram_q;
                    for (int k = 1; k < READ_LATENCY - 1; k++) begin
                        r_casc[k] <= r_casc[k-1];
                    end
                end
                assign w_last_in = r_casc[READ_LATENCY-2];
            end else begin : g_nocasc
                assign w_last_in = r_ram_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld     <= '0;
                    r_rd_data <= '0;
                end else begin
                    r_vld <= {r_vld[READ_LATENCY-1:0], w_rd_acc};
                    if (r_vld[READ_LATENCY-1]) r_rd_data <= w_last_in;
                end
            end

            assign rd_valid[gi]                       = r_vld[READ_LATENCY];
            assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = r_rd_data;
        end
    endgenerate

endmodule
